// File: rtl/mem_access_pkg.sv
// ============================================================================
// Module   : mem_access_pkg
// Brief    : Shared encodings for the data-memory access unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mem_access_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_ALIGN = 2'b01;
    localparam logic [1:0] ERR_TMO   = 2'b10;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
// ============================================================================
// Module   : mem_lane_align
// Brief    : Combinational lane steering: byte enables, store replication,
//            load right-justify/extend and misalignment detection.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_lane_align
    import mem_access_pkg::*;
#(
    parameter int DW         = 32,
    parameter int BIG_ENDIAN = 1
) (
    input  logic [1:0]               i_size,
    input  logic [$clog2(DW/8)-1:0]  i_off,
    input  logic                     i_sign_ext,
    input  logic [DW-1:0]            i_wdata,
    input  logic [DW-1:0]            i_rdata,
    output logic [DW/8-1:0]          o_be,
    output logic [DW-1:0]            o_wdata,
    output logic [DW-1:0]            o_rdata,
    output logic                     o_misaligned
);

    localparam int NB   = DW / 8;
    localparam int OFFW = $clog2(NB);

    int               w_nbytes;
    int               w_lane_lo;
    logic [OFFW-1:0]  w_mask;
    logic [DW-1:0]    w_shifted;
    logic             w_sbit;
    logic             w_ext;

    always_comb begin
        case (i_size)
            SZ_B:    w_nbytes = 1;
            SZ_H:    w_nbytes = 2;
            SZ_W:    w_nbytes = 4;
            SZ_D:    w_nbytes = 8;
            default: w_nbytes = 1;
        endcase

        // An access wider than the bus (doubleword on a 32-bit bus) is illegal.
        w_mask       = OFFW'(w_nbytes - 1);
        o_misaligned = (w_nbytes > NB) || ((i_off & w_mask) != '0);

        if (o_misaligned)
            w_lane_lo = 0;
        else if (BIG_ENDIAN != 0)
            w_lane_lo = NB - int'(i_off) - w_nbytes;
        else
            w_lane_lo = int'(i_off);

        w_shifted = i_rdata >> (8 * w_lane_lo);
        w_sbit    = 1'b0;
        o_be      = '0;
        o_wdata   = '0;
        for (int i = 0; i < NB; i++) begin
            o_be[i] = (i >= w_lane_lo) && (i < w_lane_lo + w_nbytes);
            o_wdata[8*i +: 8] = i_wdata[8*(i % w_nbytes) +: 8];
            if (i == w_nbytes - 1)
                w_sbit = w_shifted[8*i+7];
        end

        w_ext   = i_sign_ext & w_sbit;
        o_rdata = '0;
        for (int i = 0; i < NB; i++) begin
            o_rdata[8*i +: 8] = (i < w_nbytes) ? w_shifted[8*i +: 8] : {8{w_ext}};
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module   : mem_access_unit
// Brief    : Request/done data-memory access unit with lane alignment,
//            misalignment detection and wait-state timeout.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DW         = 32,
    parameter int AW         = 32,
    parameter int TIMEOUT    = 16,
    parameter int BIG_ENDIAN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             we,
    input  logic [1:0]       size,
    input  logic             sign_ext,
    input  logic [AW-1:0]    addr,
    input  logic [DW-1:0]    wdata,
    output logic             busy,
    output logic             done,
    output logic [DW-1:0]    rdata,
    output logic [1:0]       err,
    output logic [AW-1:0]    mem_addr,
    output logic [DW-1:0]    mem_wdata,
    output logic [DW/8-1:0]  mem_be,
    output logic             mem_we,
    output logic             mem_mov,
    input  logic [DW-1:0]    mem_rdata,
    input  logic             mem_moc
);

    localparam int NB   = DW / 8;
    localparam int OFFW = $clog2(NB);
    localparam int CW   = $clog2(TIMEOUT + 1);

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [1:0]      size_q, size_d;
    logic            sign_ext_q, sign_ext_d;
    logic [OFFW-1:0] off_q, off_d;
    logic [1:0]      err_q, err_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic [NB-1:0]   mem_be_q, mem_be_d;
    logic            mem_we_q, mem_we_d;
    logic            mem_mov_q, mem_mov_d;

    logic            w_idle;
    logic [1:0]      w_al_size;
    logic [OFFW-1:0] w_al_off;
    logic [NB-1:0]   w_be;
    logic [DW-1:0]   w_wdata_rep;
    logic [DW-1:0]   w_rdata_fmt;
    logic            w_misaligned;

    // The aligner sees the live request in IDLE and the latched one afterwards.
    assign w_idle    = (state_q == S_IDLE);
    assign w_al_size = w_idle ? size : size_q;
    assign w_al_off  = w_idle ? addr[OFFW-1:0] : off_q;

    mem_lane_align #(
        .DW         (DW),
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_lane_align (
        .i_size       (w_al_size),
        .i_off        (w_al_off),
        .i_sign_ext   (sign_ext_q),
        .i_wdata      (wdata),
        .i_rdata      (mem_rdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata_rep),
        .o_rdata      (w_rdata_fmt),
        .o_misaligned (w_misaligned)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        size_d      = size_q;
        sign_ext_d  = sign_ext_q;
        off_d       = off_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        mem_we_d    = mem_we_q;
        mem_mov_d   = mem_mov_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (w_misaligned) begin
                        err_d   = ERR_ALIGN;
                        state_d = S_DONE;
                    end else begin
                        we_d        = we;
                        size_d      = size;
                        sign_ext_d  = sign_ext;
                        off_d       = addr[OFFW-1:0];
                        mem_addr_d  = addr & ~AW'(NB - 1);
                        mem_wdata_d = w_wdata_rep;
                        mem_be_d    = w_be;
                        mem_we_d    = we;
                        mem_mov_d   = 1'b1;
                        cnt_d       = '0;
                        state_d     = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                // A completion on the last allowed cycle still wins over timeout.
                if (mem_moc) begin
                    if (!we_q)
                        rdata_d = w_rdata_fmt;
                    err_d     = ERR_OK;
                    mem_mov_d = 1'b0;
                    state_d   = S_DONE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d     = ERR_TMO;
                    mem_mov_d = 1'b0;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            size_q      <= '0;
            sign_ext_q  <= 1'b0;
            off_q       <= '0;
            err_q       <= '0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            mem_we_q    <= 1'b0;
            mem_mov_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            size_q      <= size_d;
            sign_ext_q  <= sign_ext_d;
            off_q       <= off_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            mem_we_q    <= mem_we_d;
            mem_mov_q   <= mem_mov_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign mem_we    = mem_we_q;
    assign mem_mov   = mem_mov_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module   : tb_mem_access_unit
// Brief    : Directed plus randomized bench for mem_access_unit (DW=32, BE).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

    localparam int DW      = 32;
    localparam int AW      = 32;
    localparam int TIMEOUT = 16;
    localparam int NB      = DW / 8;

    logic          clk = 1'b0;
    logic          reset, req, we, sign_ext, mem_moc;
    logic [1:0]    size;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, mem_rdata;
    logic          busy, done, mem_we, mem_mov;
    logic [DW-1:0] rdata, mem_wdata;
    logic [1:0]    err;
    logic [AW-1:0] mem_addr;
    logic [NB-1:0] mem_be;

    int            checks   = 0;
    int            failures = 0;
    logic [31:0]   exp_rdata;

    always #5 clk = ~clk;

    mem_access_unit #(
        .DW(DW), .AW(AW), .TIMEOUT(TIMEOUT), .BIG_ENDIAN(1)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .size(size),
        .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .busy(busy),
        .done(done), .rdata(rdata), .err(err), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_we(mem_we),
        .mem_mov(mem_mov), .mem_rdata(mem_rdata), .mem_moc(mem_moc)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: offset 0 is the most-significant byte of the bus word.
    function automatic logic [3:0] m_be(input int n, input int off);
        logic [3:0] b = '0;
        for (int j = 0; j < n; j++) b[NB-1-(off+j)] = 1'b1;
        return b;
    endfunction

    function automatic logic [31:0] m_wdata(input int n, input logic [31:0] wd);
        logic [63:0] u, r;
        u = {32'd0, wd} & ((64'd1 << (8*n)) - 64'd1);
        r = '0;
        for (int k = 0; k < NB / n; k++) r = r | (u << (8*n*k));
        return r[31:0];
    endfunction

    function automatic logic [31:0] m_rdata(input int n, input int off, input logic sx,
                                            input logic [31:0] md);
        logic [63:0] v = '0;
        for (int j = 0; j < n; j++)
            v = (v << 8) | ({32'd0, md >> (8*(NB-1-off-j))} & 64'hFF);
        if (sx && n < NB && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
        return v[31:0];
    endfunction

    task automatic run_access(input logic w, input logic [1:0] sz, input logic sx,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] md, input int moc_at, input logic inject);
        int          n, off, mov_cycles, exp_mov;
        logic        mis, got_done, addr_bad;
        logic [31:0] exp_addr;
        logic [1:0]  exp_err;
        n   = 1 << sz;
        off = int'(a % 4);
        mis = (sz == 2'b11) || ((off % n) != 0);
        req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd; mem_rdata = md;
        tick();
        req = 1'b0;
        if (mis) begin
            chk("align_done", done, 1);
            chk("align_err", err, 2'b01);
            chk("align_mov", mem_mov, 0);
            chk("align_rdata", rdata, exp_rdata);
            tick();
            chk("align_idle", {busy, done}, 2'b00);
            return;
        end
        exp_addr = a & ~32'd3;
        chk("req_mov", mem_mov, 1);
        chk("req_be", mem_be, m_be(n, off));
        chk("req_we", mem_we, w);
        chk("req_addr", mem_addr, exp_addr);
        if (w) chk("req_wdata", mem_wdata, m_wdata(n, wd));
        chk("req_busy_done", {busy, done}, 2'b10);

        mov_cycles = 0; got_done = 1'b0; addr_bad = 1'b0;
        for (int c = 0; c < TIMEOUT + 4 && !got_done; c++) begin
            if (mem_mov) mov_cycles++;
            if (mem_mov && mem_addr !== exp_addr) addr_bad = 1'b1;
            mem_moc = (c == moc_at);
            if (inject && c == 2) begin req = 1'b1; addr = a ^ 32'h100; end
            tick();
            req = 1'b0; mem_moc = 1'b0; addr = a;
            if (done) got_done = 1'b1;
        end

        exp_mov = (moc_at < TIMEOUT) ? moc_at + 1 : TIMEOUT;
        exp_err = (moc_at < TIMEOUT) ? 2'b00 : 2'b10;
        if (!w && moc_at < TIMEOUT) exp_rdata = m_rdata(n, off, sx, md);
        chk("done_seen", got_done, 1);
        chk("mov_cycles", mov_cycles, exp_mov);
        chk("done_err", err, exp_err);
        chk("done_rdata", rdata, exp_rdata);
        chk("done_mov", mem_mov, 0);
        chk("addr_stable", addr_bad, 0);
        tick();
        chk("post_idle", {busy, done}, 2'b00);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
        addr = '0; wdata = '0; mem_rdata = '0; mem_moc = 1'b0;
        exp_rdata = '0;
        tick();
        tick();
        chk("rst_flags", {busy, done, err, mem_we, mem_mov}, 6'b0);
        chk("rst_rdata", rdata, 0);
        chk("rst_mem", {mem_addr, mem_wdata, mem_be}, 68'h0);
        reset = 1'b0;
        tick();

        // store byte, moc on the 3rd ACCESS cycle
        run_access(1'b1, 2'b00, 1'b0, 32'h1001, 32'h000000AB, 32'h0, 2, 1'b0);
        // half loads, moc immediately, signed then unsigned
        run_access(1'b0, 2'b01, 1'b1, 32'h2002, 32'h0, 32'h12348001, 0, 1'b0);
        chk("half_sext", rdata, 32'hFFFF8001);
        run_access(1'b0, 2'b01, 1'b0, 32'h2002, 32'h0, 32'h12348001, 0, 1'b0);
        chk("half_zext", rdata, 32'h00008001);
        run_access(1'b0, 2'b00, 1'b1, 32'h3000, 32'h0, 32'h80FF0000, 0, 1'b0);
        chk("byte_sext", rdata, 32'hFFFFFF80);
        // misaligned word and illegal doubleword
        run_access(1'b0, 2'b10, 1'b0, 32'h4002, 32'h0, 32'h0, 0, 1'b0);
        run_access(1'b0, 2'b11, 1'b0, 32'h4000, 32'h0, 32'h0, 0, 1'b0);
        // timeout with a stray req while busy, then moc on the final cycle
        run_access(1'b0, 2'b10, 1'b0, 32'h5000, 32'h0, 32'hDEADBEEF, 100, 1'b1);
        run_access(1'b0, 2'b10, 1'b0, 32'h5004, 32'h0, 32'hCAFEF00D, TIMEOUT - 1, 1'b0);

        // reset during the 2nd ACCESS cycle
        req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h6000; wdata = 32'h11223344;
        tick();
        req = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_rdata = '0;
        chk("midrst_flags", {busy, done, err, mem_we, mem_mov}, 6'b0);
        chk("midrst_rdata", rdata, 0);
        chk("midrst_mem", {mem_addr, mem_wdata, mem_be}, 68'h0);
        tick();
        chk("midrst_nodone", {busy, done}, 2'b00);
        run_access(1'b0, 2'b10, 1'b0, 32'h6000, 32'h0, 32'h0BADF00D, 1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            int r, moc_at;
            r = int'($urandom_range(0, 9));
            moc_at = (r < 8) ? int'($urandom_range(0, 4)) : ((r == 8) ? TIMEOUT - 1 : 100);
            run_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                       moc_at, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised data-memory access unit sitting between the multi-cycle datapath (MAR/MDR side) and the data memory port.
- Generalises the single-word MOV/MOC handshake to:
  - byte, half, word and (when DW=64) doubleword accesses;
  - lane alignment, with sign or zero extension on loads;
  - misalignment detection;
  - a wait-state timeout.
- The control unit issues one request and waits for a done pulse instead of polling MOC directly.

Parameters:
- DW, 32: data width in bits; legal values 32 or 64.
- AW, 32: address width in bits.
- TIMEOUT, 16: maximum number of ACCESS cycles spent waiting for mem_moc; minimum 2.
- BIG_ENDIAN, 1: 1 = byte offset 0 maps to the most-significant lane; 0 = least-significant lane.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- req  in  1  start an access; sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- size  in  2  access size: 00 byte, 01 half, 10 word, 11 doubleword.
- sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  in  AW  byte address.
- wdata  in  DW  store data, right-justified.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle completion pulse.
- rdata  out  DW  formatted load data; held until the next load completes.
- err  out  2  00 ok, 01 misaligned/illegal size, 10 timeout; valid while done=1.
- mem_addr  out  AW  address with the low log2(DW/8) bits cleared.
- mem_wdata  out  DW  store data replicated across all lanes.
- mem_be  out  DW/8  active-high byte-lane enables.
- mem_we  out  1  1 = write cycle.
- mem_mov  out  1  memory operation valid strobe.
- mem_rdata  in  DW  memory read data.
- mem_moc  in  1  memory operation complete.

Behaviour:
- Reset: state = IDLE. busy, done, err, rdata, mem_addr, mem_wdata, mem_be, mem_we and mem_mov are all 0. The timeout counter is 0.
- Reset asserted mid-access: mem_mov drops on the next edge; no done pulse is produced.
- Offset: off = addr[log2(DW/8)-1:0].
- Misaligned or illegal request:
  - misaligned = half with off[0]≠0, word with off[1:0]≠0, or doubleword with off[2:0]≠0;
  - size=11 with DW=32 is illegal.
- FSM has three states: IDLE, ACCESS, DONE.
- IDLE, req=1, legal request:
  - latch we, size, sign_ext and off;
  - drive mem_addr, mem_wdata, mem_be and mem_we;
  - set mem_mov=1;
  - move to ACCESS.
- IDLE, req=1, misaligned/illegal: set err=01, move to DONE. No memory cycle is issued and mem_mov stays 0.
- ACCESS:
  - mem_mov and all mem_* outputs are held stable;
  - the counter increments every cycle.
- ACCESS, mem_moc=1:
  - for a load, rdata is loaded with the formatted mem_rdata;
  - err=00, mem_mov=0, move to DONE.
- ACCESS timeout: if mem_moc=0 when the counter reaches TIMEOUT-1, then err=10, mem_mov=0, move to DONE, and rdata is unchanged.
- moc on the final cycle: mem_moc=1 on the same cycle the counter reaches TIMEOUT-1 counts as success.
- DONE: done=1 for exactly one cycle, then clear the counter and return to IDLE.
- req while busy: ignored; it is not queued.
- Latency:
  - req sampled at edge t puts the unit in ACCESS from t+1;
  - moc sampled at edge t+k gives done=1 during cycle t+k+1;
  - minimum req-to-done is 2 cycles;
  - a misaligned request gives done 1 cycle after req.
- Lane index:
  - BIG_ENDIAN=1: lane = DW/8-1-off;
  - BIG_ENDIAN=0: lane = off.
- mem_be sets 1, 2, 4 or 8 contiguous bits, starting at the lowest lane of the access.
- Store data: wdata[8·n-1:0] (n = access bytes) is replicated to fill DW.
- Load data: the selected lanes are right-justified, then sign- or zero-extended to DW. Doubleword loads and word loads with DW=32 pass through unchanged.
- mem_moc outside ACCESS is ignored.

Decomposition:
- Shared package mem_access_pkg holds:
  - size encodings (SZ_B, SZ_H, SZ_W, SZ_D);
  - error codes (ERR_OK, ERR_ALIGN, ERR_TMO);
  - the state enum (S_IDLE, S_ACCESS, S_DONE).
- One combinational sub-module, mem_lane_align, takes size, off, we-data and rd-data and produces mem_be, replicated write data, formatted read data and the misaligned flag.
- The FSM, counter and output registers stay in the top module.

Test Plan (DW=32, BIG_ENDIAN=1, TIMEOUT=16):
- Store byte: we=1, size=00, addr=0x1001, wdata=0x000000AB; moc returned after 3 cycles -> mem_be=0100, mem_wdata=0xABABABAB, mem_addr=0x1000, mem_mov high 3 cycles, done 1 cycle after moc, err=00.
- Signed half load: size=01, sign_ext=1, addr=0x2002, mem_rdata=0x12348001; moc in the first ACCESS cycle -> mem_be=0011, rdata=0xFFFF8001, done 2 cycles after req. Repeat with sign_ext=0 -> rdata=0x00008001.
- Byte load: addr=0x3000, mem_rdata=0x80FF0000, sign_ext=1 -> rdata=0xFFFFFF80.
- Misaligned word: size=10, addr=0x4002 -> mem_mov never asserts, done on the next cycle, err=01. Also with size=11 -> err=01.
- Timeout: legal word load with mem_moc held 0 -> mem_mov high exactly 16 cycles, then done with err=10, rdata unchanged. A second req issued during busy has no effect.
- Reset mid-access: reset asserted in the 2nd ACCESS cycle -> all outputs are 0 the next cycle, no done pulse. A new req afterwards completes normally.
